// File: rtl/latch_load_ctrl_if.sv
// rtl/latch_load_ctrl_if.sv - board inputs and D_latch drive signals of latch_load_ctrl
interface latch_load_ctrl_if;
    logic       sw_raw;
    logic       btn_raw;
    logic       D;
    logic       enable;
    logic       busy;
    logic [7:0] load_count;

    modport master (
        output sw_raw, btn_raw,
        input  D, enable, busy, load_count
    );

    modport slave (
        input  sw_raw, btn_raw,
        output D, enable, busy, load_count
    );
endinterface

// File: rtl/latch_load_ctrl.sv
// rtl/latch_load_ctrl.sv - synchronise/debounce switch and button, run one D_latch load per press
module latch_load_ctrl #(
    parameter int DB_CYCLES = 4,
    parameter int DB_W      = 20,
    parameter int EN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    latch_load_ctrl_if.slave  bus
);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [7:0]      EN_LAST = 8'(EN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

    logic            sw_s1, sw_s2, btn_s1, btn_s2;
    logic            db_sw, db_btn, db_btn_prev;
    logic [DB_W-1:0] sw_cnt, btn_cnt;
    logic            press;

    state_t          state;
    logic [7:0]      run_cnt;
    logic            d_q, en_q, busy_q;
    logic [7:0]      count_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sw_s1       <= 1'b0;
            sw_s2       <= 1'b0;
            btn_s1      <= 1'b0;
            btn_s2      <= 1'b0;
            db_sw       <= 1'b0;
            db_btn      <= 1'b0;
            db_btn_prev <= 1'b0;
            sw_cnt      <= '0;
            btn_cnt     <= '0;
        end else begin
            sw_s1       <= bus.sw_raw;
            sw_s2       <= sw_s1;
            btn_s1      <= bus.btn_raw;
            btn_s2      <= btn_s1;
            db_btn_prev <= db_btn;

            // A new level is accepted only after DB_CYCLES consecutive differing samples
            if (sw_s2 == db_sw) begin
                sw_cnt <= '0;
            end else if (sw_cnt == DB_LAST) begin
                db_sw  <= sw_s2;
                sw_cnt <= '0;
            end else begin
                sw_cnt <= sw_cnt + 1'b1;
            end

            if (btn_s2 == db_btn) begin
                btn_cnt <= '0;
            end else if (btn_cnt == DB_LAST) begin
                db_btn  <= btn_s2;
                btn_cnt <= '0;
            end else begin
                btn_cnt <= btn_cnt + 1'b1;
            end
        end
    end

    assign press = db_btn & ~db_btn_prev;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            run_cnt <= '0;
            d_q     <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Presses are only seen here, so one arriving mid-load is dropped
                    if (press) begin
                        state  <= SETUP;
                        d_q    <= db_sw;
                        busy_q <= 1'b1;
                    end
                end
                SETUP: begin
                    state   <= OPEN;
                    en_q    <= 1'b1;
                    run_cnt <= '0;
                end
                OPEN: begin
                    if (run_cnt == EN_LAST) begin
                        state <= HOLD;
                        en_q  <= 1'b0;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                    count_q <= count_q + 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    en_q   <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.D          = d_q;
    assign bus.enable     = en_q;
    assign bus.busy       = busy_q;
    assign bus.load_count = count_q;
endmodule
